// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // Width of the iteration counter; holds WIDTH-1 down to 0.
    function automatic int unsigned count_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // Compare at WIDTH+1 bits so the shifted remainder cannot overflow; when the
    // subtraction happens the result is below the divisor, so WIDTH bits suffice.
    always_comb begin
        trial   = {rem_in, dividend_bit};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    count_q;
    // Holds the dividend magnitude, shifted left while quotient bits shift in;
    // after the last step it holds the quotient magnitude. On divide-by-zero it
    // keeps the raw dividend so it can be returned as the remainder.
    logic [WIDTH-1:0] dd_q;
    logic [WIDTH-1:0] dv_q;
    logic [WIDTH-1:0] rem_q;
    logic             neg_dd_q;
    logic             neg_dv_q;
    logic             dz_q;

    logic             sign_mode;
    logic             neg_dd_in;
    logic             neg_dv_in;
    logic [WIDTH-1:0] mag_dd_in;
    logic [WIDTH-1:0] mag_dv_in;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] fix_quot;
    logic [WIDTH-1:0] fix_rem;

    // Operand magnitudes and signs for a request presented this cycle.
    always_comb begin
        sign_mode = is_signed & SIGNED_EN;
        neg_dd_in = sign_mode & dividend[WIDTH-1];
        neg_dv_in = sign_mode & divisor[WIDTH-1];
        mag_dd_in = neg_dd_in ? -dividend : dividend;
        mag_dv_in = neg_dv_in ? -divisor : divisor;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dd_q[WIDTH-1]),
        .divisor      (dv_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Sign correction: quotient negated when signs differ, remainder follows the
    // dividend. MIN / -1 wraps naturally to MIN with a zero remainder.
    always_comb begin
        if (dz_q) begin
            fix_quot = '1;
            fix_rem  = dd_q;
        end else begin
            fix_quot = (neg_dd_q ^ neg_dv_q) ? -dd_q : dd_q;
            fix_rem  = neg_dd_q ? -rem_q : rem_q;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dd_q        <= '0;
            dv_q        <= '0;
            rem_q       <= '0;
            neg_dd_q    <= 1'b0;
            neg_dv_q    <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The done cycle still belongs to the finishing operation.
                    if (start && !done) begin
                        busy     <= 1'b1;
                        rem_q    <= '0;
                        dv_q     <= mag_dv_in;
                        neg_dd_q <= neg_dd_in;
                        neg_dv_q <= neg_dv_in;
                        count_q  <= LastCount;
                        if (divisor == '0) begin
                            dz_q    <= 1'b1;
                            dd_q    <= dividend;
                            state_q <= FIX;
                        end else begin
                            dz_q    <= 1'b0;
                            dd_q    <= mag_dd_in;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    dd_q  <= {dd_q[WIDTH-2:0], step_q};
                    if (count_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                FIX: begin
                    quotient    <= fix_quot;
                    remainder   <= fix_rem;
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
